// File: rtl/emu_code_nco_mc_if.sv
// ============================================================================
// Module   : emu_code_nco_mc_if
// Brief    : Sample/control bus of the multi-channel C/A code NCO.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface emu_code_nco_mc_if #(
  parameter int NCH = 4,
  parameter int FW  = 32,
  parameter int CW  = 10
);
  logic                dv_in;
  logic [NCH*FW-1:0]   freq;
  logic [NCH-1:0]      load;
  logic [NCH*FW-1:0]   load_phase;
  logic [NCH*10-1:0]   g2_init;
  logic [NCH-1:0]      slip;
  logic                dv_out;
  logic [NCH-1:0]      q;
  logic [NCH-1:0]      epoch;
  logic [NCH*CW-1:0]   chip_idx;

  modport master (
    output dv_in, freq, load, load_phase, g2_init, slip,
    input  dv_out, q, epoch, chip_idx
  );

  modport slave (
    input  dv_in, freq, load, load_phase, g2_init, slip,
    output dv_out, q, epoch, chip_idx
  );
endinterface

`default_nettype wire

// File: rtl/emu_code_nco_mc.sv
// ============================================================================
// Module   : emu_code_nco_mc
// Brief    : Multi-channel C/A code NCO: phase accumulator carry drives a
//            modulo-CODE_LEN chip counter and G1/G2 Gold-code LFSRs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module emu_code_nco_mc #(
  parameter int NCH      = 4,
  parameter int FW       = 32,
  parameter int CODE_LEN = 1023,
  parameter int CW       = $clog2(CODE_LEN)
) (
  input  wire logic           clk,
  input  wire logic           reset_n,
  emu_code_nco_mc_if.slave    bus
);

  localparam logic [9:0]    C_ALL_ONES = 10'h3FF;
  localparam logic [CW-1:0] C_LAST     = CW'(CODE_LEN - 1);

  logic [1:0]        r_dv_pipe;
  logic [NCH-1:0]    w_q;
  logic [NCH-1:0]    w_epoch;
  logic [NCH*CW-1:0] w_chip_idx;

  always_ff @(posedge clk or negedge reset_n) begin : p_dv_pipe
    if (!reset_n) begin
      r_dv_pipe <= 2'b00;
    end else begin
      r_dv_pipe <= {r_dv_pipe[0], bus.dv_in};
    end
  end

  generate
    for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic [FW-1:0] r_phase;
      logic          r_carry;
      logic [CW-1:0] r_chip;
      logic [9:0]    r_g1;
      logic [9:0]    r_g2;
      logic [9:0]    r_g2_latch;
      logic          r_slip_pend;
      logic          r_epoch;

      logic [FW-1:0] w_freq;
      logic [FW:0]   w_sum;
      logic [9:0]    w_g1_next;
      logic [9:0]    w_g2_next;
      logic          w_adv;
      logic          w_wrap;

      assign w_freq    = bus.freq[k*FW +: FW];
      assign w_sum     = {1'b0, r_phase} + {1'b0, w_freq};
      // Shift toward stage 10 (bit 9); feedback enters stage 1 (bit 0).
      assign w_g1_next = {r_g1[8:0], r_g1[2] ^ r_g1[9]};
      assign w_g2_next = {r_g2[8:0],
                          r_g2[1] ^ r_g2[2] ^ r_g2[5] ^ r_g2[7] ^ r_g2[8] ^ r_g2[9]};
      assign w_adv     = r_carry & ~r_slip_pend;
      assign w_wrap    = (r_chip == C_LAST);

      always_ff @(posedge clk or negedge reset_n) begin : p_stage1
        if (!reset_n) begin
          r_phase <= '0;
          r_carry <= 1'b0;
        end else if (bus.load[k]) begin
          r_phase <= bus.load_phase[k*FW +: FW];
          r_carry <= 1'b0;
        end else if (bus.dv_in) begin
          {r_carry, r_phase} <= w_sum;
        end else begin
          r_carry <= 1'b0;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin : p_stage2
        if (!reset_n) begin
          r_chip      <= '0;
          r_g1        <= C_ALL_ONES;
          r_g2        <= C_ALL_ONES;
          r_g2_latch  <= C_ALL_ONES;
          r_slip_pend <= 1'b0;
          r_epoch     <= 1'b0;
        end else if (bus.load[k]) begin
          r_chip      <= '0;
          r_g1        <= C_ALL_ONES;
          r_g2        <= bus.g2_init[k*10 +: 10];
          r_g2_latch  <= bus.g2_init[k*10 +: 10];
          r_slip_pend <= 1'b0;
          r_epoch     <= 1'b0;
        end else begin
          r_epoch <= 1'b0;
          if (w_adv) begin
            if (w_wrap) begin
              // Restart both registers so short codes repeat exactly.
              r_chip  <= '0;
              r_g1    <= C_ALL_ONES;
              r_g2    <= r_g2_latch;
              r_epoch <= 1'b1;
            end else begin
              r_chip <= r_chip + CW'(1);
              r_g1   <= w_g1_next;
              r_g2   <= w_g2_next;
            end
          end
          // A slip being consumed this cycle swallows any coincident request.
          if (r_carry && r_slip_pend) begin
            r_slip_pend <= 1'b0;
          end else if (bus.slip[k]) begin
            r_slip_pend <= 1'b1;
          end
        end
      end

      assign w_q[k]                  = r_g1[9] ^ r_g2[9];
      assign w_epoch[k]              = r_epoch;
      assign w_chip_idx[k*CW +: CW]  = r_chip;
    end
  endgenerate

  assign bus.dv_out   = r_dv_pipe[1];
  assign bus.q        = w_q;
  assign bus.epoch    = w_epoch;
  assign bus.chip_idx = w_chip_idx;

endmodule

`default_nettype wire

// File: tb/tb_emu_code_nco_mc.sv
// ============================================================================
// Module   : tb_emu_code_nco_mc
// Brief    : Directed bench for emu_code_nco_mc (CODE_LEN 1023 and 10 builds).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_emu_code_nco_mc;
  localparam int NCH = 4;
  localparam int FW  = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic                dv;
  logic [NCH*FW-1:0]   fr;
  logic [NCH*FW-1:0]   lph;
  logic [NCH-1:0]      ld;
  logic [NCH-1:0]      sl;
  logic [NCH*10-1:0]   g2i;

  emu_code_nco_mc_if #(.NCH(NCH), .FW(FW), .CW(10)) ifa ();
  emu_code_nco_mc_if #(.NCH(NCH), .FW(FW), .CW(4))  ifb ();

  assign ifa.dv_in = dv;  assign ifa.freq = fr;  assign ifa.load = ld;
  assign ifa.load_phase = lph;  assign ifa.g2_init = g2i;  assign ifa.slip = sl;
  assign ifb.dv_in = dv;  assign ifb.freq = fr;  assign ifb.load = ld;
  assign ifb.load_phase = lph;  assign ifb.g2_init = g2i;  assign ifb.slip = sl;

  emu_code_nco_mc #(.NCH(NCH), .FW(FW), .CODE_LEN(1023), .CW(10)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa.slave));
  emu_code_nco_mc #(.NCH(NCH), .FW(FW), .CODE_LEN(10), .CW(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb.slave));

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] chip_of(int d, int k);
    return (d == 0) ? ifa.chip_idx[k*10 +: 10] : {6'b0, ifb.chip_idx[k*4 +: 4]};
  endfunction
  function automatic logic q_of(int d, int k);
    return (d == 0) ? ifa.q[k] : ifb.q[k];
  endfunction
  function automatic logic ep_of(int d, int k);
    return (d == 0) ? ifa.epoch[k] : ifb.epoch[k];
  endfunction

  // Model: phase as plain integer sum, chip as a counter, code bits looked up
  // from a per-channel table of the whole code period built on load.
  int              LEN [2] = '{1023, 10};
  longint unsigned m_phase [2][NCH];
  bit              m_carry [2][NCH];
  int              m_chip  [2][NCH];
  bit              m_pend  [2][NCH];
  bit              m_epoch [2][NCH];
  bit              tbl     [2][NCH][1023];
  bit              m_d0, m_dvo;

  task automatic build(input int d, input int k, input logic [9:0] g2);
    logic [9:0] a, b;
    a = 10'h3FF;
    b = g2;
    for (int n = 0; n < LEN[d]; n++) begin
      tbl[d][k][n] = a[9] ^ b[9];
      a = {a[8:0], a[2] ^ a[9]};
      b = {b[8:0], b[1] ^ b[2] ^ b[5] ^ b[7] ^ b[8] ^ b[9]};
    end
  endtask

  task automatic mreset();
    m_d0 = 1'b0;
    m_dvo = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < NCH; k++) begin
        m_phase[d][k] = 0; m_carry[d][k] = 0; m_chip[d][k] = 0;
        m_pend[d][k] = 0;  m_epoch[d][k] = 0;
        build(d, k, 10'h3FF);
      end
  endtask

  task automatic mstep();
    longint unsigned s;
    bit c;
    m_dvo = m_d0;
    m_d0  = dv;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < NCH; k++) begin
        if (ld[k]) begin
          m_phase[d][k] = lph[k*FW +: FW];
          m_carry[d][k] = 0; m_chip[d][k] = 0; m_pend[d][k] = 0; m_epoch[d][k] = 0;
          build(d, k, g2i[k*10 +: 10]);
        end else begin
          c = m_carry[d][k];
          m_epoch[d][k] = 0;
          if (c && m_pend[d][k]) begin
            m_pend[d][k] = 0;
          end else begin
            if (c) begin
              m_chip[d][k]  = (m_chip[d][k] + 1) % LEN[d];
              m_epoch[d][k] = (m_chip[d][k] == 0);
            end
            if (sl[k]) m_pend[d][k] = 1;
          end
          if (dv) begin
            s = m_phase[d][k] + longint'(fr[k*FW +: FW]);
            m_carry[d][k] = s[32];
            m_phase[d][k] = s % 64'h1_0000_0000;
          end else begin
            m_carry[d][k] = 0;
          end
        end
      end
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk);
      if (!reset_n) mreset();
      else mstep();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && chk_en) begin
        chk("dv_out_a", {31'b0, ifa.dv_out}, {31'b0, m_dvo});
        chk("dv_out_b", {31'b0, ifb.dv_out}, {31'b0, m_dvo});
        for (int d = 0; d < 2; d++)
          for (int k = 0; k < NCH; k++) begin
            chk($sformatf("q d%0d ch%0d", d, k), {31'b0, q_of(d, k)},
                {31'b0, tbl[d][k][m_chip[d][k]]});
            chk($sformatf("epoch d%0d ch%0d", d, k), {31'b0, ep_of(d, k)},
                {31'b0, m_epoch[d][k]});
            chk($sformatf("chip d%0d ch%0d", d, k), {22'b0, chip_of(d, k)},
                m_chip[d][k]);
          end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < NCH; k++) begin
        chk($sformatf("%s q d%0d ch%0d", tag, d, k), {31'b0, q_of(d, k)}, 0);
        chk($sformatf("%s ep d%0d ch%0d", tag, d, k), {31'b0, ep_of(d, k)}, 0);
        chk($sformatf("%s chip d%0d ch%0d", tag, d, k), {22'b0, chip_of(d, k)}, 0);
      end
    chk({tag, " dv_out"}, {31'b0, ifa.dv_out}, 0);
  endtask

  logic [9:0] bits;
  logic [9:0] prev, cur;
  bit         per [2][1023];
  int         nep, adv, mism;
  int         advs [NCH];
  int         eps  [NCH];
  logic [9:0] prevb [NCH];

  initial begin
    dv = 0; fr = '0; lph = '0; ld = '0; sl = '0; g2i = {NCH{10'h3FF}};
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // PRN1 on all channels, freq 2^31, load coincident with a sample.
    @(negedge clk);
    fr  = {NCH{32'h8000_0000}};
    g2i = {NCH{10'h0DF}};
    ld  = '1;
    dv  = 1'b1;
    @(posedge clk); #1;
    chk("load chip0", {22'b0, chip_of(0, 0)}, 0);
    chk("load q0", {31'b0, ifa.q[0]}, 1);
    chk("dv lag e0", {31'b0, ifa.dv_out}, 0);
    @(negedge clk);
    ld = '0;
    bits = '0;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      if (c == 1) chk("dv lag e1", {31'b0, ifa.dv_out}, 1);
      if (c == 2) chk("chip stays 0", {22'b0, chip_of(0, 0)}, 0);
      if (c == 3) chk("chip first adv", {22'b0, chip_of(0, 0)}, 1);
      if (chip_of(0, 0) < 10) bits[9 - chip_of(0, 0)] = ifa.q[0];
    end
    chk("PRN1 first 10", {22'b0, bits}, {22'b0, 10'b1100100000});

    // Single slip on ch1.
    @(negedge clk); sl = 4'b0010;
    @(negedge clk); sl = 4'b0000;
    repeat (10) @(posedge clk);
    #1;
    chk("slip lag", (32'(chip_of(0, 0)) + 1023 - 32'(chip_of(0, 1))) % 1023, 1);

    // Reload ch0/ch1, then two slips before the first carry.
    @(negedge clk); ld = 4'b0011;
    @(negedge clk); ld = 4'b0000; sl = 4'b0010;
    @(negedge clk); sl = 4'b0010;
    @(negedge clk); sl = 4'b0000;
    repeat (12) @(posedge clk);
    #1;
    chk("double slip lag", (32'(chip_of(0, 0)) + 1023 - 32'(chip_of(0, 1))) % 1023, 1);

    // Load on ch3 while a carry is in flight.
    @(negedge clk);
    fr[3*FW +: FW]  = 32'd1;
    lph[3*FW +: FW] = 32'hFFFF_FFFF;
    ld = 4'b1000;
    @(negedge clk); ld = 4'b0000;
    @(negedge clk);
    lph[3*FW +: FW] = 32'hFFFF_FFFE;
    ld = 4'b1000;
    @(posedge clk); #1;
    chk("reload chip", {22'b0, chip_of(0, 3)}, 0);
    @(negedge clk); ld = 4'b0000;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("reload c%0d", c), {22'b0, chip_of(0, 3)}, (c == 3) ? 1 : 0);
    end

    // Full-rate ch2: two complete 1023-chip periods.
    @(negedge clk);
    fr[2*FW +: FW]  = 32'hFFFF_FFFF;
    lph[2*FW +: FW] = 32'd0;
    ld = 4'b0100;
    @(posedge clk); #1;
    @(negedge clk); ld = 4'b0000;
    nep = 0; adv = 0; prev = 10'd0;
    per[0][0] = ifa.q[2];
    for (int c = 0; c < 2400 && nep < 2; c++) begin
      @(posedge clk); #1;
      cur = chip_of(0, 2);
      if (cur != prev) adv++;
      if (ifa.epoch[2]) begin
        nep++;
        chk($sformatf("wrap from e%0d", nep), {22'b0, prev}, 1022);
        chk($sformatf("chips per epoch e%0d", nep), adv, 1023);
        adv = 0;
      end
      if (nep < 2) per[nep][cur] = ifa.q[2];
      prev = cur;
    end
    chk("epochs seen", nep, 2);
    mism = 0;
    for (int n = 0; n < 1023; n++) if (per[0][n] != per[1][n]) mism++;
    chk("period repeat", mism, 0);
    bits = '0;
    for (int n = 0; n < 10; n++) bits[9 - n] = per[0][n];
    chk("fullrate PRN1", {22'b0, bits}, {22'b0, 10'b1100100000});

    // Distinct rates and codes, short-code build watched on dut_b.
    @(negedge clk);
    fr  = {32'hC000_0000, 32'hFFFF_FFFF, 32'h4000_0000, 32'h8000_0000};
    lph = '0;
    g2i = {10'h2F8, 10'h37C, 10'h1BE, 10'h0DF};
    ld  = '1;
    @(negedge clk); ld = '0;
    for (int k = 0; k < NCH; k++) begin advs[k] = 0; eps[k] = 0; prevb[k] = 0; end
    for (int c = 0; c < 240; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NCH; k++) begin
        cur = chip_of(1, k);
        if (cur != prevb[k]) advs[k]++;
        if (ifb.epoch[k]) begin
          eps[k]++;
          chk($sformatf("short wrap ch%0d", k), {22'b0, prevb[k]}, 9);
        end
        prevb[k] = cur;
      end
    end
    for (int k = 0; k < NCH; k++)
      chk($sformatf("short epochs ch%0d", k), eps[k], advs[k] / 10);
    chk("short ch2 busy", {31'b0, eps[2] > 20}, 1);

    // Asynchronous reset mid-run.
    @(negedge clk);
    chk_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post q0", {31'b0, ifa.q[0]}, 0);
    chk("post chip0", {22'b0, chip_of(0, 0)}, 0);
    chk_en = 1'b1;
    repeat (30) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
